// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the stride-2 convolver frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

   localparam int Q_INT_BITS  = 8;
   localparam int Q_FRAC_BITS = 8;
   localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WLOAD  = 3'd1,
      CLR    = 3'd2,
      STREAM = 3'd3,
      RUN    = 3'd4,
      FIN    = 3'd5
   } state_t;

   // Output feature-map side for a padded, strided square convolution
   function automatic int calc_o(input int n_side, input int k_side, input int stride, input int pad);
      return (n_side + 2 * pad - k_side) / stride + 1;
   endfunction

   // Number of kernel weight words held on the flat weight bus
   function automatic int calc_w(input int k_side, input int in_ch, input int out_ch);
      return k_side * k_side * in_ch * out_ch;
   endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Output feature-map write path: channel-change detect, per-channel index, total count, address.
// Latency: one cycle from an accepted result to the registered buffer write.
// Backpressure: none; illegal results (bad channel or index overflow) are dropped and flagged.
module ofm_addr_gen
   import conv_pkg::*;
#(
   parameter int N            = Q_WIDTH,
   parameter int OO           = 16,
   parameter int OUT_CHANNELS = 2,
   parameter int AW           = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          cap_vld_i,
   input  logic [4:0]    cap_ch_i,
   input  logic [N-1:0]  cap_dat_i,
   output logic          bad_o,
   output logic [31:0]   total_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [N-1:0]  wr_dat_o
);

   localparam int IW = $clog2(OO + 1);

   logic          first_q, first_d;
   logic [4:0]    prev_ch_q, prev_ch_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [31:0]   total_q, total_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [N-1:0]  wr_dat_q, wr_dat_d;
   logic [IW-1:0] idx;
   logic          take;

   // Slot for the offered result and whether it is legal; total_o already includes it
   always_comb begin
      idx = '0;
      if (!first_q && cap_ch_i == prev_ch_q) begin
         idx = cnt_q;
      end
      bad_o   = cap_vld_i && ((32'(cap_ch_i) >= 32'(OUT_CHANNELS)) || (32'(idx) >= 32'(OO)));
      take    = cap_vld_i && !bad_o;
      total_o = total_q + 32'(take);
   end

   // Counter update and write-port staging; suppressed writes leave the channel history alone
   always_comb begin
      first_d   = first_q;
      prev_ch_d = prev_ch_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_dat_d  = wr_dat_q;
      if (clear_i) begin
         first_d   = 1'b1;
         prev_ch_d = '0;
         cnt_d     = '0;
         total_d   = '0;
      end else if (take) begin
         first_d   = 1'b0;
         prev_ch_d = cap_ch_i;
         cnt_d     = idx + IW'(1);
         total_d   = total_o;
         wr_en_d   = 1'b1;
         wr_addr_d = AW'(32'(cap_ch_i) * 32'(OO) + 32'(idx));
         wr_dat_d  = cap_dat_i;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         first_q   <= 1'b1;
         prev_ch_q <= '0;
         cnt_q     <= '0;
         total_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
      end else begin
         first_q   <= first_d;
         prev_ch_q <= prev_ch_d;
         cnt_q     <= cnt_d;
         total_q   <= total_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_dat_q  <= wr_dat_d;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_dat_o  = wr_dat_q;

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer: weight load, convolver clear, pixel stream, result collection, host status.
// Latency: W+1 load cycles, 1 clear cycle, n*n+1 stream cycles; result writes land 1 cycle after conv_valid.
// Backpressure: none; ROM and image buffer are fixed 1-cycle reads, RUN aborts after TIMEOUT idle cycles.
module conv_scheduler
   import conv_pkg::*;
#(
   parameter int N            = Q_WIDTH,
   parameter int n            = 224,
   parameter int k            = 3,
   parameter int s            = 2,
   parameter int p            = 1,
   parameter int IN_CHANNELS  = 1,
   parameter int OUT_CHANNELS = 16,
   parameter int TIMEOUT      = 4096,
   localparam int O           = calc_o(n, k, s, p),
   localparam int W           = calc_w(k, IN_CHANNELS, OUT_CHANNELS),
   localparam int WAW         = $clog2(W),
   localparam int IAW         = $clog2(n * n),
   localparam int OAW         = $clog2(O * O * OUT_CHANNELS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WAW-1:0]   w_rd_addr,
   input  logic [N-1:0]     w_rd_data,
   output logic [IAW-1:0]   img_rd_addr,
   input  logic [N-1:0]     img_rd_data,
   output logic             conv_rst,
   output logic             conv_en,
   output logic [N-1:0]     conv_act,
   output logic [W*N-1:0]   conv_weight,
   input  logic [N-1:0]     conv_out,
   input  logic [4:0]       conv_channel,
   input  logic             conv_valid,
   input  logic             conv_done,
   output logic             ofm_wr_en,
   output logic [OAW-1:0]   ofm_wr_addr,
   output logic [N-1:0]     ofm_wr_data
);

   localparam int PIX   = n * n;
   localparam int OO    = O * O;
   localparam int TOTAL = OO * OUT_CHANNELS;
   localparam int WCW   = $clog2(W + 1);
   localparam int PCW   = $clog2(PIX + 1);
   localparam int TCW   = $clog2(TIMEOUT + 1);

   state_t         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic           err_q, err_d;
   logic [W*N-1:0] weight_q;
   logic           start_acc;
   logic           cap_vld;
   logic           cap_bad;
   logic [31:0]    wr_total;

   // Results are only collected while pixels are in flight or draining
   assign cap_vld = conv_valid && (state_q == STREAM || state_q == RUN);

   // Sequencer next state, counters and convolver/host controls
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      pcnt_d    = pcnt_q;
      tcnt_d    = tcnt_q;
      err_d     = err_q;
      start_acc = 1'b0;
      busy      = (state_q != IDLE);
      done      = 1'b0;
      conv_rst  = rst;
      conv_en   = 1'b0;
      conv_act  = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               err_d     = 1'b0;
               wcnt_d    = '0;
               state_d   = WLOAD;
            end
         end
         WLOAD: begin
            // Last cycle only captures the final word; no new address is consumed
            if (wcnt_q == WCW'(W)) begin
               wcnt_d  = '0;
               pcnt_d  = '0;
               state_d = CLR;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         CLR: begin
            conv_rst = 1'b1;
            state_d  = STREAM;
         end
         STREAM: begin
            // Pixel for address j arrives one cycle later, so cycle 0 carries nothing
            if (pcnt_q != '0) begin
               conv_en  = 1'b1;
               conv_act = img_rd_data;
            end
            if (pcnt_q == PCW'(PIX)) begin
               pcnt_d  = '0;
               tcnt_d  = '0;
               state_d = RUN;
            end else begin
               pcnt_d = pcnt_q + PCW'(1);
            end
         end
         RUN: begin
            conv_en = 1'b1;
            tcnt_d  = conv_valid ? '0 : tcnt_q + TCW'(1);
            if (conv_done) begin
               state_d = FIN;
               // wr_total counts a result arriving alongside conv_done
               if (wr_total != 32'(TOTAL)) begin
                  err_d = 1'b1;
               end
            end else if (!conv_valid && tcnt_q == TCW'(TIMEOUT - 1)) begin
               state_d = FIN;
               err_d   = 1'b1;
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (cap_bad) begin
         err_d = 1'b1;
      end
   end

   // Sequencer registers; reset aborts any frame without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         pcnt_q  <= '0;
         tcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pcnt_q  <= pcnt_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
      end
   end

   // Weight capture: word i lands the cycle after address i was issued, then holds until the next load
   always_ff @(posedge clk) begin
      if (rst) begin
         weight_q <= '0;
      end else if (state_q == WLOAD) begin
         for (int i = 0; i < W; i++) begin
            if (wcnt_q == WCW'(i + 1)) begin
               weight_q[i*N +: N] <= w_rd_data;
            end
         end
      end
   end

   assign err         = err_q;
   assign conv_weight = weight_q;
   assign w_rd_addr   = WAW'(wcnt_q);
   assign img_rd_addr = IAW'(pcnt_q);

   ofm_addr_gen #(
      .N            (N),
      .OO           (OO),
      .OUT_CHANNELS (OUT_CHANNELS),
      .AW           (OAW)
   ) u_ofm_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (start_acc),
      .cap_vld_i (cap_vld),
      .cap_ch_i  (conv_channel),
      .cap_dat_i (conv_out),
      .bad_o     (cap_bad),
      .total_o   (wr_total),
      .wr_en_o   (ofm_wr_en),
      .wr_addr_o (ofm_wr_addr),
      .wr_dat_o  (ofm_wr_data)
   );

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler with reduced frame (n=8, O=4, W=18, two output channels).
// Latency: expected buffer writes are queued at stimulus time and retired by a negedge monitor.
// Backpressure: n/a; all waits are bounded.
`timescale 1ns/1ps
module tb_conv_scheduler;

   localparam int N   = 16;
   localparam int NS  = 8;
   localparam int OC  = 2;
   localparam int TO  = 16;
   localparam int W   = 18;
   localparam int WAW = 5;
   localparam int IAW = 6;
   localparam int OAW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             busy, done, err;
   logic [WAW-1:0]   w_rd_addr;
   logic [N-1:0]     w_rd_data = '0;
   logic [IAW-1:0]   img_rd_addr;
   logic [N-1:0]     img_rd_data = '0;
   logic             conv_rst, conv_en;
   logic [N-1:0]     conv_act;
   logic [W*N-1:0]   conv_weight;
   logic [N-1:0]     conv_out = '0;
   logic [4:0]       conv_channel = '0;
   logic             conv_valid = 1'b0;
   logic             conv_done = 1'b0;
   logic             ofm_wr_en;
   logic [OAW-1:0]   ofm_wr_addr;
   logic [N-1:0]     ofm_wr_data;

   conv_scheduler #(
      .N(N), .n(NS), .k(3), .s(2), .p(1),
      .IN_CHANNELS(1), .OUT_CHANNELS(OC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
      .conv_rst(conv_rst), .conv_en(conv_en), .conv_act(conv_act), .conv_weight(conv_weight),
      .conv_out(conv_out), .conv_channel(conv_channel), .conv_valid(conv_valid), .conv_done(conv_done),
      .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data)
   );

   always #5 clk = ~clk;

   // Weight ROM holds i+1 at address i; image pixel j is 0x100+j; both read in one cycle
   always @(posedge clk) begin
      w_rd_data   <= 16'(w_rd_addr) + 16'd1;
      img_rd_data <= 16'h0100 + 16'(img_rd_addr);
   end

   typedef struct packed {
      logic [OAW-1:0] addr;
      logic [N-1:0]   dat;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  wr_cnt   = 0;
   int  done_cnt = 0;
   int  crst_cnt = 0;
   int  pix_idx  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Monitor: retire buffer writes against the scoreboard, count pulses, check the pixel stream
   always @(negedge clk) begin
      wr_t e;
      if (ofm_wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", ofm_wr_addr, ofm_wr_data);
         end else begin
            e = exp_q.pop_front();
            check("ofm_write", {ofm_wr_addr, ofm_wr_data}, {e.addr, e.dat});
         end
      end
      if (done) done_cnt++;
      if (conv_rst && !rst) crst_cnt++;
      if (conv_rst) begin
         pix_idx = 0;
      end else if (conv_en && conv_act != '0) begin
         check("pixel", conv_act, 64'(16'h0100 + 16'(pix_idx)));
         pix_idx++;
      end
   end

   task automatic start_frame();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("err_cleared_on_start", err, 0);
   endtask

   task automatic wait_en();
      bit found = 0;
      repeat (100) begin
         @(negedge clk);
         if (conv_en) begin found = 1; break; end
      end
      check("conv_en_seen", found, 1);
   endtask

   task automatic wait_run();
      bit found = 0;
      repeat (200) begin
         @(negedge clk);
         if (conv_en && conv_act == '0) begin found = 1; break; end
      end
      check("run_seen", found, 1);
   endtask

   task automatic wait_done();
      bit found = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) begin found = 1; break; end
      end
      check("done_seen", found, 1);
   endtask

   task automatic drive_valid(input logic [4:0] ch, input logic [N-1:0] dat, input bit exp_wr,
                              input logic [OAW-1:0] addr, input bit with_done);
      wr_t e;
      conv_valid   = 1'b1;
      conv_channel = ch;
      conv_out     = dat;
      conv_done    = with_done;
      if (exp_wr) begin
         e.addr = addr;
         e.dat  = dat;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      conv_valid = 1'b0;
      conv_done  = 1'b0;
   endtask

   task automatic drive_done();
      conv_done = 1'b1;
      @(posedge clk);
      #1;
      conv_done = 1'b0;
   endtask

   // Complete frame: last result arrives in the same cycle as conv_done
   task automatic run_full(input string tag);
      int base_wr, base_done;
      base_wr   = wr_cnt;
      base_done = done_cnt;
      wait_en();
      for (int j = 0; j < 16; j++) drive_valid(5'd0, 16'hA000 + 16'(j), 1, OAW'(j), 0);
      for (int j = 0; j < 15; j++) drive_valid(5'd1, 16'hB000 + 16'(j), 1, OAW'(16 + j), 0);
      wait_run();
      drive_valid(5'd1, 16'hB00F, 1, OAW'(31), 1);
      wait_done();
      @(negedge clk);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy_after_fin"}, busy, 0);
      check({tag, "_done_pulses"}, done_cnt - base_done, 1);
      check({tag, "_writes"}, wr_cnt - base_wr, 32);
      check({tag, "_pixels"}, pix_idx, 64);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base_wr, base_done, base_crst, cyc;
      bit found;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_conv_rst", conv_rst, 1);
      check("rst_conv_en", conv_en, 0);
      check("rst_ofm_wr_en", ofm_wr_en, 0);
      check("rst_weight_zero", conv_weight == '0, 1);
      check("rst_w_addr", w_rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;

      // Weight load and full frame
      base_crst = crst_cnt;
      start_frame();
      repeat (18) @(posedge clk);
      #1;
      check("w17_not_yet", conv_weight[17*16 +: 16], 0);
      check("conv_rst_in_wload", conv_rst, 0);
      @(posedge clk);
      #1;
      check("conv_rst_clr", conv_rst, 1);
      for (int i = 0; i < W; i++) check("weight_word", conv_weight[i*16 +: 16], 64'(i + 1));
      @(posedge clk);
      #1;
      check("conv_rst_one_cycle", conv_rst, 0);
      run_full("full");
      check("conv_rst_pulses", crst_cnt - base_crst, 1);

      // Short frame: conv_done after 20 results
      base_wr = wr_cnt;
      start_frame();
      wait_en();
      for (int j = 0; j < 16; j++) drive_valid(5'd0, 16'h1000 + 16'(j), 1, OAW'(j), 0);
      for (int j = 0; j < 4; j++)  drive_valid(5'd1, 16'h2000 + 16'(j), 1, OAW'(16 + j), 0);
      wait_run();
      drive_done();
      wait_done();
      check("short_err", err, 1);
      @(negedge clk);
      check("short_writes", wr_cnt - base_wr, 20);

      // Bad channel, then per-channel index overflow
      base_wr = wr_cnt;
      start_frame();
      wait_en();
      drive_valid(5'd3, 16'hDEAD, 0, '0, 0);
      check("bad_ch_err", err, 1);
      for (int j = 0; j < 16; j++) drive_valid(5'd0, 16'h3000 + 16'(j), 1, OAW'(j), 0);
      drive_valid(5'd0, 16'hBEEF, 0, '0, 0);
      wait_run();
      check("bad_err_sticky", err, 1);
      drive_done();
      wait_done();
      @(negedge clk);
      check("bad_writes", wr_cnt - base_wr, 16);
      check("bad_err_final", err, 1);

      // Timeout: one result in RUN, then silence
      start_frame();
      wait_run();
      drive_valid(5'd1, 16'hC001, 1, OAW'(16), 0);
      cyc   = 0;
      found = 0;
      repeat (60) begin
         @(negedge clk);
         cyc++;
         if (done) begin found = 1; break; end
      end
      check("timeout_done_seen", found, 1);
      // Write lands in cycle 1, TIMEOUT idle cycles follow it, FIN is the next cycle
      check("timeout_cycles", cyc, TO + 1);
      check("timeout_err", err, 1);
      @(negedge clk);

      // Reset mid-stream at pixel 30
      start_frame();
      found = 0;
      repeat (200) begin
         @(negedge clk);
         if (pix_idx >= 30) begin found = 1; break; end
      end
      check("reached_pixel_30", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_conv_en", conv_en, 0);
      check("mid_rst_conv_act", conv_act, 0);
      check("mid_rst_conv_rst", conv_rst, 1);
      check("mid_rst_img_addr", img_rd_addr, 0);
      check("mid_rst_weight_zero", conv_weight == '0, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      base_done = done_cnt;
      repeat (20) @(negedge clk);
      check("mid_rst_no_done", done_cnt - base_done, 0);
      check("mid_rst_idle", busy, 0);
      start_frame();
      run_full("after_rst");

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/conv_scheduler.md
# conv_scheduler

Frame-level sequencer for the first-block stride-2 convolver. On a host `start` it loads all kernel weights from the weight ROM into the convolver's flat weight bus, clears the convolver, and streams one input frame from the image buffer at one pixel per cycle. It then collects the convolver's `valid_out` results into the output feature-map buffer in channel-major order, and reports completion or error to the host.

## Interface
Parameters:
- `N` = 16: data word width (Q8.8)
- `n` = 224: input frame side
- `k` = 3: kernel side
- `s` = 2: stride
- `p` = 1: padding
- `IN_CHANNELS` = 1: input channels
- `OUT_CHANNELS` = 16: output channels
- `TIMEOUT` = 4096: max idle cycles in RUN before abort

Derived constants: `O = (n+2p-k)/s + 1`; `W = k*k*IN_CHANNELS*OUT_CHANNELS`.

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous and active-high
- `start` in 1: one-cycle frame request, sampled only in IDLE
- `busy` out 1: high from the cycle after an accepted `start` until FIN exits
- `done` out 1: one-cycle pulse in FIN
- `err` out 1: sticky error flag; cleared by `rst` or by the next accepted `start`
- `w_rd_addr` out clog2(W): weight ROM address; ROM read latency is 1 cycle
- `w_rd_data` in N: weight ROM data
- `img_rd_addr` out clog2(n*n): image buffer address, raster order; read latency is 1 cycle
- `img_rd_data` in N: pixel data
- `conv_rst` out 1: convolver reset
- `conv_en` out 1: convolver enable
- `conv_act` out N: activation to the convolver
- `conv_weight` out W*N: packed weights; word i sits at `[i*N +: N]`
- `conv_out` in N: convolver result
- `conv_channel` in 5: result channel
- `conv_valid` in 1: result strobe
- `conv_done` in 1: convolver done pulse
- `ofm_wr_en` out 1: output buffer write enable
- `ofm_wr_addr` out clog2(O*O*OUT_CHANNELS): output buffer address
- `ofm_wr_data` out N: output buffer data

## Operation
- **IDLE**: `start` moves to WLOAD and clears `err`. `start` in any other state is ignored.
- **WLOAD**:
  - Issues `w_rd_addr` 0..W-1, one address per cycle.
  - On the cycle after address i, writes `w_rd_data` into word i of `conv_weight`.
  - Moves to CLR after the last word is captured.
  - `conv_weight` holds its value until the next WLOAD. Reset clears it to 0.
- **CLR**: drives `conv_rst`=1 for exactly 1 cycle, then moves to STREAM.
- **STREAM**:
  - Issues `img_rd_addr` 0..n*n-1, one address per cycle.
  - `conv_en`=1 and `conv_act`=`img_rd_data` from the cycle after the first address.
  - Moves to RUN on the cycle the last pixel is presented.
- **RUN**:
  - Holds `conv_en`=1 and `conv_act`=0.
  - Moves to FIN on `conv_done`.
  - Also moves to FIN with `err`=1 if `TIMEOUT` consecutive cycles pass with no `conv_valid`.
- **FIN**: drops `conv_en`, pulses `done` for 1 cycle, returns to IDLE.
- **Output capture** (STREAM and RUN):
  - On `conv_valid`, write `ofm_wr_data`=`conv_out` to `ofm_wr_addr` = `conv_channel*O*O + idx`.
  - `idx` is a per-channel counter. It resets to 0 whenever `conv_channel` differs from the channel of the previous write; the first write of a frame uses `idx`=0.
- **Error rules**:
  - `conv_channel` ≥ `OUT_CHANNELS`, or `idx` ≥ `O*O`: suppress the write and set `err`.
  - `conv_done` arrives while the total write count ≠ `O*O*OUT_CHANNELS`: set `err`. `done` is still pulsed.
  - `conv_valid` outside STREAM and RUN is ignored.

## Timing
- Reset values: every output is 0 except `conv_rst`, which is 1 while `rst` is high. State is IDLE and all counters are 0.
- Reset during any state aborts the frame. The state returns to IDLE the cycle after `rst` deasserts, and no `done` is pulsed.
- `busy` rises 1 cycle after `start`.
- Cycle counts:
  - WLOAD: W+1 cycles.
  - CLR: 1 cycle.
  - STREAM: n*n cycles of `conv_en` carrying pixels.
- The output write is registered: `ofm_wr_en` fires 1 cycle after the `conv_valid` it captures.
- `conv_done` and `conv_valid` in the same cycle: the write is performed and counted before the count check.
- The timeout counter resets on every `conv_valid` and on entry to RUN.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum (IDLE, WLOAD, CLR, STREAM, RUN, FIN);
  - functions computing `O` and `W` from parameters;
  - the Q8.8 width constants.
- One sub-module, `ofm_addr_gen`: the channel-change detect, per-channel `idx` counter, total counter, and address multiply-add.

## Test plan
Use reduced parameters n=8, k=3, s=2, p=1, OUT_CHANNELS=2, so O=4 and W=18. The convolver is a behavioural model.

1. Weight load: ROM word i = i+1, pulse `start` → after 19 cycles `conv_weight[i*16 +: 16]` = i+1 for all i; `conv_rst` pulses once.
2. Full frame: model emits 16 valids on ch0 then 16 on ch1, then `conv_done` → 32 writes to addresses 0..31, `done` pulses once, `err`=0.
3. Short frame: `conv_done` after only 20 valids → `done` pulses, `err`=1.
4. Bad channel: `conv_valid` with `conv_channel`=3 → no write, `err`=1.
5. Timeout with `TIMEOUT`=16: model never asserts `conv_done` → FIN 16 cycles after the last valid, `err`=1.
6. Reset mid-STREAM at pixel 30: all outputs 0, `busy`=0, `done` never pulses; a second `start` then completes normally.
